// File: rtl/crc_table_writer_if.sv
// Write port between the CRC table generator and the table RAM it fills.
// master drives entries; slave is the RAM side that accepts them.
interface crc_table_writer_if;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/crc_table_writer.sv
// Generates a 256-entry CRC byte table (optionally advanced over ADV zero bytes) into a RAM.
// Define CRC_TABLE_REFLECT_EN to build the reflected (LSB-first) table instead of the normal one.
module crc_table_writer #(
  parameter logic [31:0] POLY = 32'h04C11DB7,
  parameter int          ADV  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  crc_table_writer_if.master  wr
);

  localparam int         NSTEP     = 8 * (ADV + 1);
  localparam logic [6:0] LAST_STEP = 7'(NSTEP - 1);

`ifdef CRC_TABLE_REFLECT_EN
  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) r[k] = v[31-k];
    return r;
  endfunction

  localparam logic [31:0] POLY_R = rev32(POLY);

  function automatic logic [31:0] load_val(input logic [7:0] i);
    return {24'h0, i};
  endfunction

  function automatic logic [31:0] bit_step(input logic [31:0] c);
    return c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
  endfunction
`else
  function automatic logic [31:0] load_val(input logic [7:0] i);
    return {i, 24'h0};
  endfunction

  function automatic logic [31:0] bit_step(input logic [31:0] c);
    return c[31] ? ((c << 1) ^ POLY) : (c << 1);
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

  state_t      state_q;
  logic [7:0]  idx_q;
  logic [6:0]  step_q;
  logic [31:0] crc_q;
  logic        busy_q;
  logic        done_q;
  logic        wr_en_q;

  logic [7:0]  idx_d;
  logic [31:0] crc_d;

  assign idx_d = idx_q + 8'd1;
  assign crc_d = bit_step(crc_q);

  // crc_q and idx_q stay frozen in WRITE, so they double as the held write payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      step_q  <= '0;
      crc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            idx_q   <= '0;
            crc_q   <= load_val(8'h00);
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          crc_q  <= crc_d;
          step_q <= step_q + 7'd1;
          if (step_q == LAST_STEP) begin
            wr_en_q <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (wr.wr_ready) begin
            wr_en_q <= 1'b0;
            if (idx_q == 8'hFF) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_d;
              crc_q   <= load_val(idx_d);
              step_q  <= '0;
              state_q <= CALC;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = idx_q;
  assign wr.wr_data = crc_q;

endmodule
